mem_request_scheduler: RTL
==========================

# mem_request_scheduler

Schedules the instruction cache and data cache requests onto a single-ported main memory.
- Three requesters share the port: icache block read, dcache block read and dcache block write-back.
- Each requester gets its own valid/ready slot.
- Grants are round-robin, with a read-after-write ordering rule for the dcache.
- At most one memory transaction is in flight; read responses are routed back to the originating cache.

## Interface
- ADDRESS_BITS, 32, width of every address port
- ICACHE_BLOCK_DW, 256, icache block width in bits
- DCACHE_BLOCK_DW, 256, dcache block width in bits; mem_resp_data_i width is max(ICACHE_BLOCK_DW, DCACHE_BLOCK_DW)
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- icache_valid_i / icache_ready_o / icache_address_i  in/out/in  1/1/ADDRESS_BITS  icache read request
- dcache_valid_i / dcache_ready_o / dcache_address_i  in/out/in  1/1/ADDRESS_BITS  dcache read request
- dcache_valid_wr / dcache_ready_wr / dcache_address_wr / dcache_data_wr  in/out/in/in  1/1/ADDRESS_BITS/DCACHE_BLOCK_DW  dcache write-back
- mem_req_valid_o, mem_req_ready_i  out/in  1/1  memory request handshake
- mem_req_write_o  out  1  1 = write, 0 = read
- mem_req_address_o  out  ADDRESS_BITS  request address
- mem_req_data_o  out  DCACHE_BLOCK_DW  write data; all-zero for reads
- mem_resp_valid_i, mem_resp_data_i  in  1/max DW  read response (writes produce no response)
- icache_valid_o, icache_data_o  out  1/ICACHE_BLOCK_DW  icache response, low ICACHE_BLOCK_DW bits of the memory data
- dcache_valid_o, dcache_address_o, dcache_data_o  out  1/ADDRESS_BITS/DCACHE_BLOCK_DW  dcache read response plus original address
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky: mem_resp_valid_i seen outside WAIT_RESP

## Operation
- Slots. One holding slot per requester (IC, DR, DW) stores address and, for DW, data.
  - ready = slot empty, driven directly from the slot full flag.
  - A request is accepted on a valid&ready edge.
  - A slot frees only when its transaction completes.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE.
  - If any slot is eligible, pick a winner.
  - Load the mem_req_* registers from the winner's slot and go to ISSUE.
  - Otherwise stay in IDLE.
- Eligibility. DR is ineligible while DW is full, so a pending write-back always precedes a dcache read (RAW ordering).
- Round-robin.
  - Order is IC(0), DR(1), DW(2).
  - Search starts at (last_grant+1) mod 3.
  - last_grant updates at the grant.
  - Reset value of last_grant is 2, so IC wins first.
- ISSUE.
  - mem_req_valid_o = 1; request fields stay stable until the handshake.
  - On mem_req_ready_i, a write clears the DW slot and returns to IDLE.
  - On mem_req_ready_i, a read goes to WAIT_RESP.
- WAIT_RESP.
  - On mem_resp_valid_i, register the data to the owner's response outputs and pulse the owner's valid for exactly one cycle.
  - dcache_address_o = the slot address.
  - Then clear the owner's slot and go to IDLE.
- Stray response. mem_resp_valid_i in IDLE or ISSUE is ignored and sets err_o. err_o is cleared only by rst.
- Response data outputs hold their last value between pulses.
- Simultaneous events.
  - A slot that completes on edge E can accept a new request no earlier than E+1, since ready is low during the completing cycle.
  - New arrivals at other slots during ISSUE or WAIT_RESP are accepted normally and compete at the next IDLE.

## Timing
- Reset (rst high at an edge) sets:
  - all slots empty; FSM = IDLE; last_grant = 2
  - mem_req_valid_o = 0, mem_req_write_o = 0, mem_req_address_o = 0, mem_req_data_o = 0
  - icache_valid_o = 0, dcache_valid_o = 0; all data and address outputs = 0
  - busy_o = 0, err_o = 0
  - ready outputs = 1 from the first cycle after reset
- Reset mid-transaction discards the in-flight request. A response arriving after reset counts as stray (err_o set).
- Edge timeline for a read:
  - E0: request accepted.
  - E1: grant; mem_req_valid_o high from E1.
  - E2: earliest memory handshake (zero-wait memory).
  - E3: earliest response edge.
  - E3 to E4: icache_valid_o or dcache_valid_o is high; the slot's ready returns high.
- Minimum read latency, accept edge to response valid: 3 cycles plus memory wait states.
- Write occupancy: accept at E0, slot free after the handshake at E2.
- Back-to-back: IDLE costs one cycle between transactions. Peak rate is one write per 2 cycles or one read per 3 cycles with zero-wait memory.

## Test plan
- Single icache read at address 0x0000_0040; memory readies immediately and responds at the next edge with data 0xA5… (256 b) -> icache_valid_o pulses once at E3–E4 with 0xA5…; dcache_valid_o stays 0; err_o stays 0.
- IC, DR and DW all asserted on the same cycle; DW address 0x100 with data 0x1, DR address 0x100 -> grant order IC, DW, DR. dcache_address_o = 0x100 on the dcache read response.
- IC continuously valid, DW issues 3 write-backs -> grants alternate IC, DW, IC, DW, IC, DW; no requester waits more than 2 grants.
- mem_req_ready_i held low for 10 cycles during ISSUE -> mem_req_* held stable for all 10 cycles; exactly one handshake; slots keep accepting.
- mem_resp_valid_i pulsed while in IDLE -> no valid output; err_o rises and stays 1 until rst.
- rst asserted in WAIT_RESP, response arrives 2 cycles later -> all outputs 0 after reset, no response pulse, err_o = 1, ready outputs = 1.

Source files
------------

// File: rtl/mem_request_scheduler_if.sv
// Bundle of request, memory and response signals between the caches, the
// scheduler and main memory. The scheduler uses the master view.
interface mem_request_scheduler_if #(
  parameter int ADDRESS_BITS    = 32,
  parameter int ICACHE_BLOCK_DW = 256,
  parameter int DCACHE_BLOCK_DW = 256
);
  localparam int MEM_DW = (ICACHE_BLOCK_DW > DCACHE_BLOCK_DW) ? ICACHE_BLOCK_DW : DCACHE_BLOCK_DW;

  logic                       icache_valid_i;
  logic                       icache_ready_o;
  logic [ADDRESS_BITS-1:0]    icache_address_i;
  logic                       dcache_valid_i;
  logic                       dcache_ready_o;
  logic [ADDRESS_BITS-1:0]    dcache_address_i;
  logic                       dcache_valid_wr;
  logic                       dcache_ready_wr;
  logic [ADDRESS_BITS-1:0]    dcache_address_wr;
  logic [DCACHE_BLOCK_DW-1:0] dcache_data_wr;

  logic                       mem_req_valid_o;
  logic                       mem_req_ready_i;
  logic                       mem_req_write_o;
  logic [ADDRESS_BITS-1:0]    mem_req_address_o;
  logic [DCACHE_BLOCK_DW-1:0] mem_req_data_o;
  logic                       mem_resp_valid_i;
  logic [MEM_DW-1:0]          mem_resp_data_i;

  logic                       icache_valid_o;
  logic [ICACHE_BLOCK_DW-1:0] icache_data_o;
  logic                       dcache_valid_o;
  logic [ADDRESS_BITS-1:0]    dcache_address_o;
  logic [DCACHE_BLOCK_DW-1:0] dcache_data_o;
  logic                       busy_o;
  logic                       err_o;

  modport master (
    input  icache_valid_i, icache_address_i,
    input  dcache_valid_i, dcache_address_i,
    input  dcache_valid_wr, dcache_address_wr, dcache_data_wr,
    output icache_ready_o, dcache_ready_o, dcache_ready_wr,
    output mem_req_valid_o, mem_req_write_o, mem_req_address_o, mem_req_data_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output icache_valid_o, icache_data_o,
    output dcache_valid_o, dcache_address_o, dcache_data_o,
    output busy_o, err_o
  );

  modport slave (
    output icache_valid_i, icache_address_i,
    output dcache_valid_i, dcache_address_i,
    output dcache_valid_wr, dcache_address_wr, dcache_data_wr,
    input  icache_ready_o, dcache_ready_o, dcache_ready_wr,
    input  mem_req_valid_o, mem_req_write_o, mem_req_address_o, mem_req_data_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  icache_valid_o, icache_data_o,
    input  dcache_valid_o, dcache_address_o, dcache_data_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler of icache reads, dcache reads and dcache write-backs
// onto a single-ported memory with one transaction in flight.
module mem_request_scheduler #(
  parameter int ADDRESS_BITS    = 32,
  parameter int ICACHE_BLOCK_DW = 256,
  parameter int DCACHE_BLOCK_DW = 256
) (
  input logic                     clk,
  input logic                     rst,
  mem_request_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                     state_reg, state_next;
  logic                       slot_full_reg [3];
  logic [ADDRESS_BITS-1:0]    slot_addr_reg [3];
  logic [ADDRESS_BITS-1:0]    req_addr [3];
  logic [2:0]                 req_valid;
  logic [2:0]                 eligible;
  logic [2:0]                 slot_done;
  logic [DCACHE_BLOCK_DW-1:0] wb_data_reg;

  logic [1:0]                 last_grant_reg, owner_reg;
  logic [1:0]                 cand0, cand1, cand2, grant_idx;
  logic                       grant_found, load_req, resp_take;

  logic                       req_write_reg;
  logic [ADDRESS_BITS-1:0]    req_addr_reg;
  logic [DCACHE_BLOCK_DW-1:0] req_data_reg;
  logic                       icache_valid_reg, dcache_valid_reg, err_reg;
  logic [ICACHE_BLOCK_DW-1:0] icache_data_reg;
  logic [DCACHE_BLOCK_DW-1:0] dcache_data_reg;
  logic [ADDRESS_BITS-1:0]    dcache_addr_reg;

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  assign req_valid   = {bus.dcache_valid_wr, bus.dcache_valid_i, bus.icache_valid_i};
  assign req_addr[0] = bus.icache_address_i;
  assign req_addr[1] = bus.dcache_address_i;
  assign req_addr[2] = bus.dcache_address_wr;

  // Slot storage: a slot fills on valid&ready and empties only on completion.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_full_reg[gi] <= 1'b0;
        slot_addr_reg[gi] <= '0;
      end else if (req_valid[gi] && !slot_full_reg[gi]) begin
        slot_full_reg[gi] <= 1'b1;
        slot_addr_reg[gi] <= req_addr[gi];
      end else if (slot_done[gi]) begin
        slot_full_reg[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_reg <= '0;
    end else if (bus.dcache_valid_wr && !slot_full_reg[2]) begin
      wb_data_reg <= bus.dcache_data_wr;
    end
  end

  assign bus.icache_ready_o  = !slot_full_reg[0];
  assign bus.dcache_ready_o  = !slot_full_reg[1];
  assign bus.dcache_ready_wr = !slot_full_reg[2];

  // A pending write-back blocks dcache reads so reads never overtake it.
  assign eligible = {slot_full_reg[2], slot_full_reg[1] && !slot_full_reg[2], slot_full_reg[0]};

  always_comb begin
    cand0       = rr_next(last_grant_reg);
    cand1       = rr_next(cand0);
    cand2       = rr_next(cand1);
    grant_found = 1'b1;
    grant_idx   = cand0;
    if (eligible[cand0])      grant_idx = cand0;
    else if (eligible[cand1]) grant_idx = cand1;
    else if (eligible[cand2]) grant_idx = cand2;
    else                      grant_found = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    slot_done  = 3'b000;
    load_req   = 1'b0;
    resp_take  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          load_req   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready_i) begin
          if (req_write_reg) begin
            slot_done[2] = 1'b1;
            state_next   = IDLE;
          end else begin
            state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid_i) begin
          resp_take            = 1'b1;
          slot_done[owner_reg] = 1'b1;
          state_next           = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg   <= 2'd2;
      owner_reg        <= 2'd0;
      req_write_reg    <= 1'b0;
      req_addr_reg     <= '0;
      req_data_reg     <= '0;
      icache_valid_reg <= 1'b0;
      dcache_valid_reg <= 1'b0;
      icache_data_reg  <= '0;
      dcache_data_reg  <= '0;
      dcache_addr_reg  <= '0;
      err_reg          <= 1'b0;
    end else begin
      icache_valid_reg <= 1'b0;
      dcache_valid_reg <= 1'b0;
      if (load_req) begin
        owner_reg      <= grant_idx;
        last_grant_reg <= grant_idx;
        req_write_reg  <= (grant_idx == 2'd2);
        req_addr_reg   <= slot_addr_reg[grant_idx];
        req_data_reg   <= (grant_idx == 2'd2) ? wb_data_reg : '0;
      end
      if (resp_take) begin
        if (owner_reg == 2'd0) begin
          icache_valid_reg <= 1'b1;
          icache_data_reg  <= bus.mem_resp_data_i[ICACHE_BLOCK_DW-1:0];
        end else begin
          dcache_valid_reg <= 1'b1;
          dcache_data_reg  <= bus.mem_resp_data_i[DCACHE_BLOCK_DW-1:0];
          dcache_addr_reg  <= slot_addr_reg[1];
        end
      end
      // Responses are only meaningful while a read is outstanding.
      if (bus.mem_resp_valid_i && state_reg != WAIT_RESP) err_reg <= 1'b1;
    end
  end

  assign bus.mem_req_valid_o   = (state_reg == ISSUE);
  assign bus.mem_req_write_o   = req_write_reg;
  assign bus.mem_req_address_o = req_addr_reg;
  assign bus.mem_req_data_o    = req_data_reg;
  assign bus.icache_valid_o    = icache_valid_reg;
  assign bus.icache_data_o     = icache_data_reg;
  assign bus.dcache_valid_o    = dcache_valid_reg;
  assign bus.dcache_address_o  = dcache_addr_reg;
  assign bus.dcache_data_o     = dcache_data_reg;
  assign bus.busy_o            = (state_reg != IDLE);
  assign bus.err_o             = err_reg;
endmodule
